fir_coef_ctrl: RTL and testbench
================================

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 Parameter: DRAIN_CYC, default 16, number of idle cycles inserted before a coefficient swap; legal range 0..255.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_n  in  1  reset, synchronous, active-low.
REQ-004 DIN_UP  in  8  upstream sample.
REQ-005 VIN_UP  in  1  upstream sample valid.
REQ-006 RDY_UP  out  1  upstream ready; sample transfers when VIN_UP=1 and RDY_UP=1 in the same cycle.
REQ-007 DIN  out  8  sample to FIR_filter DIN.
REQ-008 VIN  out  1  sample valid to FIR_filter VIN.
REQ-009 CFG_VALID  in  1  coefficient write request.
REQ-010 CFG_ADDR  in  4  tap index 0..10.
REQ-011 CFG_DATA  in  8  coefficient value, two's complement.
REQ-012 CFG_READY  out  1  write accepted when CFG_VALID=1 and CFG_READY=1.
REQ-013 COMMIT  in  1  single-cycle request to apply shadow coefficients.
REQ-014 H0..H10  out  8 each  active coefficients to FIR_filter H0..H10.
REQ-015 BUSY  out  1  high while a commit is in progress.
REQ-016 DONE  out  1  one-cycle pulse when the swap occurs.
REQ-017 ERR  out  1  one-cycle pulse for an accepted write with CFG_ADDR>10.

Function
REQ-018 Storage: 11x8 shadow bank (write side) and 11x8 active bank (drives H0..H10); the active bank changes only in SWAP.
REQ-019 FSM states: RUN, HOLD, SWAP; 8-bit down-counter CNT.
REQ-020 RUN: RDY_UP=1, CFG_READY=1, BUSY=0; COMMIT=1 -> HOLD with CNT<=DRAIN_CYC.
REQ-021 HOLD: RDY_UP=0, CFG_READY=0, BUSY=1; CNT=0 -> SWAP, else CNT<=CNT-1; HOLD lasts exactly DRAIN_CYC+1 cycles.
REQ-022 SWAP (exactly 1 cycle): active<=shadow (all 11 taps at once), DONE=1, BUSY=1, RDY_UP=0, CFG_READY=0; -> RUN; new H values are visible on the first RUN cycle.
REQ-023 Data path, registered, latency 1: each cycle DIN<=DIN_UP and VIN<=VIN_UP AND RDY_UP.
REQ-024 VIN is 0 for every cycle that follows a HOLD or SWAP cycle, so no sample reaches the filter while the pipeline drains or the coefficients change.
REQ-025 Accepted write with CFG_ADDR<=10: shadow[CFG_ADDR]<=CFG_DATA; active bank unchanged.
REQ-026 Accepted write with CFG_ADDR in 11..15: no storage change; ERR=1 on the next cycle (registered); ERR=0 otherwise.
REQ-027 Write and COMMIT in the same RUN cycle: the write lands in shadow and is included in the following swap.
REQ-028 COMMIT while in HOLD or SWAP: ignored (no queueing, no restart of CNT).
REQ-029 Repeated writes to one tap before a commit: the last write wins.
REQ-030 DRAIN_CYC=0: sequence is RUN -> HOLD (1 cycle) -> SWAP -> RUN.

Reset
REQ-031 RST_n=0 at a rising edge: state RUN, CNT=0, both banks all 0, DIN=0, VIN=0, DONE=0, ERR=0.
REQ-032 Combinational outputs follow the RUN state after reset: RDY_UP=1, CFG_READY=1, BUSY=0.
REQ-033 Reset asserted during HOLD or SWAP aborts the commit: the active bank is zeroed and does not take the shadow contents.

Verification
REQ-034 Reset then 5 cycles idle -> H0..H10=0, VIN=0, RDY_UP=1, BUSY=0, DONE=0.
REQ-035 Write taps 0..10 = 1..11, then COMMIT with DRAIN_CYC=16 -> BUSY high 18 cycles, DONE pulses on the 18th, H5=6 on the next cycle, H unchanged before that.
REQ-036 Stream VIN_UP=1, DIN_UP=0x10,0x11,... across a commit -> VIN drops 1 cycle after RDY_UP drops, no sample lost or duplicated, stream resumes with the first unaccepted value.
REQ-037 Write CFG_ADDR=12, CFG_DATA=0x55 -> ERR pulses 1 cycle, both banks unchanged.
REQ-038 Write tap3=0x7F and COMMIT in the same cycle, plus a second COMMIT during HOLD -> H3=0x7F after exactly one swap and one DONE pulse.
REQ-039 Assert RST_n=0 during HOLD -> next cycle state RUN, H all 0, DONE never pulses.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: double-buffered coefficient loader and sample gate for an
// 11-tap FIR filter. Writes land in a shadow bank; COMMIT drains the
// sample pipeline for DRAIN_CYC+1 cycles, then copies shadow to active.
//
// Ports:
//   CLK, RST_n             clock, synchronous active-low reset
//   DIN_UP, VIN_UP, RDY_UP upstream sample handshake
//   DIN, VIN               registered sample stream to the filter
//   CFG_VALID/ADDR/DATA    coefficient write request, CFG_READY accepts
//   COMMIT                 request to apply shadow coefficients
//   H0..H10                active coefficients
//   BUSY, DONE, ERR        commit in progress, swap pulse, bad-address pulse
module fir_coef_ctrl #(
    parameter int DRAIN_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [7:0] DIN_UP,
    input  logic       VIN_UP,
    output logic       RDY_UP,
    output logic [7:0] DIN,
    output logic       VIN,
    input  logic       CFG_VALID,
    input  logic [3:0] CFG_ADDR,
    input  logic [7:0] CFG_DATA,
    output logic       CFG_READY,
    input  logic       COMMIT,
    output logic [7:0] H0,
    output logic [7:0] H1,
    output logic [7:0] H2,
    output logic [7:0] H3,
    output logic [7:0] H4,
    output logic [7:0] H5,
    output logic [7:0] H6,
    output logic [7:0] H7,
    output logic [7:0] H8,
    output logic [7:0] H9,
    output logic [7:0] H10,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYC);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] shadow [11];
    logic [7:0] active [11];
    logic       wr_acc;
    logic       wr_ok;

    assign wr_acc = CFG_VALID & CFG_READY;
    assign wr_ok  = (CFG_ADDR <= 4'd10);

    // State register and drain counter
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == RUN && COMMIT) begin
                cnt <= DRAIN_LD;
            end else if (state == HOLD && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Next state; COMMIT outside RUN is simply not looked at
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (COMMIT) state_nxt = HOLD;
            HOLD:    if (cnt == 8'd0) state_nxt = SWAP;
            SWAP:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        RDY_UP    = 1'b0;
        CFG_READY = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            RUN: begin
                RDY_UP    = 1'b1;
                CFG_READY = 1'b1;
            end
            HOLD: begin
                BUSY = 1'b1;
            end
            SWAP: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Coefficient banks; writes are only accepted in RUN, so the swap
    // never races a shadow write.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            for (int i = 0; i < 11; i++) begin
                shadow[i] <= 8'd0;
                active[i] <= 8'd0;
            end
        end else begin
            if (wr_acc && wr_ok) begin
                shadow[CFG_ADDR] <= CFG_DATA;
            end
            if (state == SWAP) begin
                for (int i = 0; i < 11; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Sample path and error flag; gating VIN with RDY_UP keeps the
    // filter input quiet for every cycle after a HOLD or SWAP cycle.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            DIN <= 8'd0;
            VIN <= 1'b0;
            ERR <= 1'b0;
        end else begin
            DIN <= DIN_UP;
            VIN <= VIN_UP & RDY_UP;
            ERR <= wr_acc & ~wr_ok;
        end
    end

    assign H0  = active[0];
    assign H1  = active[1];
    assign H2  = active[2];
    assign H3  = active[3];
    assign H4  = active[4];
    assign H5  = active[5];
    assign H6  = active[6];
    assign H7  = active[7];
    assign H8  = active[8];
    assign H9  = active[9];
    assign H10 = active[10];

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed and randomized bench for fir_coef_ctrl with a
// cycle-level reference model (busy window length, shadow/active arrays).
module tb_fir_coef_ctrl;

    localparam int DRAIN = 16;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [7:0] DIN_UP;
    logic       VIN_UP;
    logic       RDY_UP;
    logic [7:0] DIN;
    logic       VIN;
    logic       CFG_VALID;
    logic [3:0] CFG_ADDR;
    logic [7:0] CFG_DATA;
    logic       CFG_READY;
    logic       COMMIT;
    logic [7:0] H0, H1, H2, H3, H4, H5, H6, H7, H8, H9, H10;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [7:0] h [11];

    always #5 CLK = ~CLK;

    fir_coef_ctrl #(.DRAIN_CYC(DRAIN)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .DIN_UP(DIN_UP), .VIN_UP(VIN_UP), .RDY_UP(RDY_UP),
        .DIN(DIN), .VIN(VIN),
        .CFG_VALID(CFG_VALID), .CFG_ADDR(CFG_ADDR),
        .CFG_DATA(CFG_DATA), .CFG_READY(CFG_READY),
        .COMMIT(COMMIT),
        .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5),
        .H6(H6), .H7(H7), .H8(H8), .H9(H9), .H10(H10),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    assign h[0] = H0;
    assign h[1] = H1;
    assign h[2] = H2;
    assign h[3] = H3;
    assign h[4] = H4;
    assign h[5] = H5;
    assign h[6] = H6;
    assign h[7] = H7;
    assign h[8] = H8;
    assign h[9] = H9;
    assign h[10] = H10;

    // Reference model: m_left counts remaining busy cycles of a commit
    // (DRAIN+1 drain cycles plus the swap cycle); 0 means running.
    logic [7:0] m_sh  [11];
    logic [7:0] m_act [11];
    int         m_left;
    logic [7:0] m_din;
    logic       m_vin;
    logic       m_err;

    int         checks = 0;
    int         errors = 0;
    int         dones;
    int         busy_n;
    bit         last_acc;
    bit         sb_on = 1'b0;
    logic [7:0] exp_rx;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit ready;
        ready = (m_left == 0);
        last_acc = RST_n && ready && VIN_UP;
        if (!RST_n) begin
            for (int i = 0; i < 11; i++) begin
                m_sh[i]  = 8'd0;
                m_act[i] = 8'd0;
            end
            m_left = 0;
            m_din  = 8'd0;
            m_vin  = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_din = DIN_UP;
            m_vin = VIN_UP && ready;
            m_err = CFG_VALID && ready && (CFG_ADDR > 4'd10);
            if (m_left == 1) m_act = m_sh;
            if (CFG_VALID && ready && CFG_ADDR <= 4'd10)
                m_sh[CFG_ADDR] = CFG_DATA;
            if (m_left > 0) m_left--;
            else if (COMMIT) m_left = DRAIN + 2;
        end
        @(posedge CLK);
        #1;
        chk("RDY_UP", {7'd0, RDY_UP}, {7'd0, m_left == 0});
        chk("CFG_READY", {7'd0, CFG_READY}, {7'd0, m_left == 0});
        chk("BUSY", {7'd0, BUSY}, {7'd0, m_left != 0});
        chk("DONE", {7'd0, DONE}, {7'd0, m_left == 1});
        chk("ERR", {7'd0, ERR}, {7'd0, m_err});
        chk("VIN", {7'd0, VIN}, {7'd0, m_vin});
        chk("DIN", DIN, m_din);
        for (int i = 0; i < 11; i++)
            chk($sformatf("H%0d", i), h[i], m_act[i]);
        if (DONE === 1'b1) dones++;
        if (sb_on && VIN === 1'b1) begin
            chk("stream", DIN, exp_rx);
            exp_rx = exp_rx + 8'd1;
        end
    endtask

    initial begin
        RST_n = 1'b0;
        DIN_UP = 8'd0;
        VIN_UP = 1'b0;
        CFG_VALID = 1'b0;
        CFG_ADDR = 4'd0;
        CFG_DATA = 8'd0;
        COMMIT = 1'b0;
        m_left = 0;
        dones = 0;
        exp_rx = 8'd0;

        // Reset and idle
        repeat (2) cycle();
        RST_n = 1'b1;
        repeat (5) cycle();

        // Load taps 1..11 and commit
        for (int i = 0; i < 11; i++) begin
            CFG_VALID = 1'b1;
            CFG_ADDR = 4'(i);
            CFG_DATA = 8'(i + 1);
            cycle();
        end
        CFG_VALID = 1'b0;
        COMMIT = 1'b1;
        dones = 0;
        busy_n = 0;
        cycle();
        busy_n += int'(BUSY);
        COMMIT = 1'b0;
        repeat (20) begin
            cycle();
            busy_n += int'(BUSY);
        end
        chk("busy_len", 8'(busy_n), 8'd18);
        chk("done_cnt1", 8'(dones), 8'd1);
        chk("H5_after", H5, 8'd6);

        // Out-of-range write
        CFG_VALID = 1'b1;
        CFG_ADDR = 4'd12;
        CFG_DATA = 8'h55;
        cycle();
        chk("err_pulse", {7'd0, ERR}, 8'd1);
        CFG_VALID = 1'b0;
        repeat (2) cycle();

        // Stream across a commit
        sb_on = 1'b1;
        exp_rx = 8'h10;
        DIN_UP = 8'h10;
        VIN_UP = 1'b1;
        repeat (4) begin
            cycle();
            if (last_acc) DIN_UP = DIN_UP + 8'd1;
        end
        COMMIT = 1'b1;
        cycle();
        if (last_acc) DIN_UP = DIN_UP + 8'd1;
        COMMIT = 1'b0;
        repeat (25) begin
            cycle();
            if (last_acc) DIN_UP = DIN_UP + 8'd1;
        end
        VIN_UP = 1'b0;
        repeat (2) cycle();
        sb_on = 1'b0;
        chk("stream_cnt", exp_rx, DIN_UP);

        // Write + commit together, extra commit in HOLD
        dones = 0;
        CFG_VALID = 1'b1;
        CFG_ADDR = 4'd3;
        CFG_DATA = 8'h7F;
        COMMIT = 1'b1;
        cycle();
        CFG_VALID = 1'b0;
        COMMIT = 1'b0;
        repeat (3) cycle();
        COMMIT = 1'b1;
        cycle();
        COMMIT = 1'b0;
        repeat (25) cycle();
        chk("H3_7f", H3, 8'h7F);
        chk("done_cnt2", 8'(dones), 8'd1);

        // Reset during HOLD aborts the commit
        CFG_VALID = 1'b1;
        CFG_ADDR = 4'd0;
        CFG_DATA = 8'hA5;
        cycle();
        CFG_VALID = 1'b0;
        dones = 0;
        COMMIT = 1'b1;
        cycle();
        COMMIT = 1'b0;
        repeat (5) cycle();
        RST_n = 1'b0;
        cycle();
        RST_n = 1'b1;
        chk("H0_rst", H0, 8'd0);
        repeat (20) cycle();
        chk("done_cnt3", 8'(dones), 8'd0);

        // Randomized traffic
        repeat (600) begin
            CFG_VALID = 1'($urandom_range(0, 1));
            CFG_ADDR = 4'($urandom_range(0, 15));
            CFG_DATA = 8'($urandom);
            COMMIT = ($urandom_range(0, 19) == 0);
            VIN_UP = 1'($urandom_range(0, 1));
            DIN_UP = 8'($urandom);
            RST_n = ($urandom_range(0, 149) != 0);
            cycle();
        end
        RST_n = 1'b1;
        CFG_VALID = 1'b0;
        COMMIT = 1'b0;
        VIN_UP = 1'b0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
